// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver states and the
// rounded baud divider used by both the receiver and the transmitter.
package uart_pkg;

   localparam int C_PAR_NONE = 0;
   localparam int C_PAR_ODD  = 1;
   localparam int C_PAR_EVEN = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_DONE,
      S_WAIT_HIGH
   } state_t;

   function automatic int f_baud_div(input int freq, input int baud);
      return (freq + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Loadable down-counter: after a load of L it emits a one-cycle tick
// L cycles later, then idles at zero until the next load.
module uart_baud_tick #(
   parameter int G_DIV = 104
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         load,
   input  logic [$clog2(G_DIV+1)-1:0]   load_val,
   output logic                         tick
);

   localparam int C_W = $clog2(G_DIV + 1);

   logic [C_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (load) begin
         cnt_q <= load_val;
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - C_W'(1);
      end
   end

   assign tick = (cnt_q == C_W'(1));

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver with parity, framing and break detection;
// keeps the receiving/dat_ready/dat_o contract of the fixed 8N1 uart_rx.
module uart_rx_cfg
   import uart_pkg::*;
#(
   parameter int G_FREQ_CLK  = 12_000_000,
   parameter int G_BAUD      = 115200,
   parameter int G_DATA_BITS = 8,
   parameter int G_PARITY    = 0,
   parameter int G_STOP_BITS = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   uart_rx,
   output logic                   receiving,
   output logic                   dat_ready,
   output logic [G_DATA_BITS-1:0] dat_o,
   output logic                   parity_err,
   output logic                   frame_err,
   output logic                   break_det
);

   localparam int C_DIV  = f_baud_div(G_FREQ_CLK, G_BAUD);
   localparam int C_HALF = C_DIV / 2;
   localparam int C_CW   = $clog2(C_DIV + 1);

   localparam logic [C_CW-1:0] C_LD_DIV  = C_CW'(C_DIV);
   localparam logic [C_CW-1:0] C_LD_HALF = C_CW'(C_HALF);
   localparam logic [3:0] C_LAST_DATA = 4'(G_DATA_BITS - 1);
   localparam logic [3:0] C_LAST_STOP = 4'(G_STOP_BITS - 1);

   logic rx_meta;
   logic rx_s;

   state_t state_q;
   state_t state_d;

   logic            tick;
   logic            load;
   logic [C_CW-1:0] load_val;

   logic                   cnt_clr;
   logic                   cnt_inc;
   logic                   shift_en;
   logic                   par_en;
   logic                   stop_en;
   logic                   commit;
   logic [3:0]             bit_cnt_q;
   logic [G_DATA_BITS-1:0] shift_q;
   logic                   par_q;
   logic                   stop_err_q;

   logic frame_now;
   logic par_xor;
   logic par_now;

   logic [G_DATA_BITS-1:0] dat_q;
   logic                   perr_q;
   logic                   ferr_q;
   logic                   brk_q;

   uart_baud_tick #(
      .G_DIV (C_DIV)
   ) u_tick (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .load_val (load_val),
      .tick     (tick)
   );

   // Idle-high reset value keeps a reset release from looking like a start bit
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= uart_rx;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      load     = 1'b0;
      load_val = C_LD_DIV;
      cnt_clr  = 1'b0;
      cnt_inc  = 1'b0;
      shift_en = 1'b0;
      par_en   = 1'b0;
      stop_en  = 1'b0;
      commit   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (!rx_s) begin
               state_d  = S_START;
               load     = 1'b1;
               load_val = C_LD_HALF;
            end
         end
         S_START: begin
            if (tick) begin
               if (rx_s) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DATA;
                  load    = 1'b1;
                  cnt_clr = 1'b1;
               end
            end
         end
         S_DATA: begin
            if (tick) begin
               shift_en = 1'b1;
               load     = 1'b1;
               cnt_inc  = 1'b1;
               if (bit_cnt_q == C_LAST_DATA) begin
                  cnt_clr = 1'b1;
                  state_d = (G_PARITY != C_PAR_NONE) ? S_PARITY : S_STOP;
               end
            end
         end
         S_PARITY: begin
            if (tick) begin
               par_en  = 1'b1;
               load    = 1'b1;
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (tick) begin
               stop_en = 1'b1;
               if (bit_cnt_q == C_LAST_STOP) begin
                  commit  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  load    = 1'b1;
                  cnt_inc = 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = ferr_q ? S_WAIT_HIGH : S_IDLE;
         end
         S_WAIT_HIGH: begin
            if (rx_s) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         stop_err_q <= 1'b0;
      end else begin
         if (cnt_clr) begin
            bit_cnt_q  <= '0;
            stop_err_q <= 1'b0;
         end else if (cnt_inc) begin
            bit_cnt_q <= bit_cnt_q + 4'd1;
         end
         if (shift_en) begin
            shift_q <= {rx_s, shift_q[G_DATA_BITS-1:1]};
         end
         if (par_en) begin
            par_q <= rx_s;
         end
         if (stop_en && !rx_s) begin
            stop_err_q <= 1'b1;
         end
      end
   end

   // Final stop sample is folded in directly so all flags land with dat_o
   assign frame_now = stop_err_q | ~rx_s;
   assign par_xor   = ^{shift_q, par_q};
   assign par_now   = (G_PARITY == C_PAR_ODD)  ? ~par_xor :
                      (G_PARITY == C_PAR_EVEN) ?  par_xor : 1'b0;

   always_ff @(posedge clk) begin
      if (rst) begin
         dat_q  <= '0;
         perr_q <= 1'b0;
         ferr_q <= 1'b0;
         brk_q  <= 1'b0;
      end else if (commit) begin
         dat_q  <= shift_q;
         perr_q <= par_now;
         ferr_q <= frame_now;
         brk_q  <= frame_now & ~|shift_q;
      end
   end

   assign receiving  = (state_q == S_START) || (state_q == S_DATA) ||
                       (state_q == S_PARITY) || (state_q == S_STOP);
   assign dat_ready  = (state_q == S_DONE);
   assign dat_o      = dat_q;
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;
   assign break_det  = brk_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: four receiver configurations driven with
// directed and random frames, checked against a bit-level frame model.
module tb_uart_rx_cfg;

   localparam int DIV  = 104;
   localparam int HALF = 52;

   typedef struct packed {
      logic [8:0] dat;
      logic       pe;
      logic       fe;
      logic       bk;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic line [4];
   logic recv [4];
   logic rdy  [4];
   logic pe   [4];
   logic fe   [4];
   logic bk   [4];
   logic [7:0] dat0, dat1, dat2;
   logic [6:0] dat3;
   logic [8:0] datv [4];

   int cyc = 0;
   int n_chk = 0;
   int n_pass = 0;
   int rdy_cnt [4];
   int rdy_cyc [4];
   int rise_cyc [4];
   int fall_cyc [4];
   logic [8:0] cap_dat [4];
   logic cap_pe [4];
   logic cap_fe [4];
   logic cap_bk [4];
   logic recv_prev [4];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   assign datv[0] = {1'b0, dat0};
   assign datv[1] = {1'b0, dat1};
   assign datv[2] = {1'b0, dat2};
   assign datv[3] = {2'b0, dat3};

   uart_rx_cfg u_8n1 (
      .clk(clk), .rst(rst), .uart_rx(line[0]), .receiving(recv[0]),
      .dat_ready(rdy[0]), .dat_o(dat0), .parity_err(pe[0]),
      .frame_err(fe[0]), .break_det(bk[0]));

   uart_rx_cfg #(.G_PARITY(2)) u_8e1 (
      .clk(clk), .rst(rst), .uart_rx(line[1]), .receiving(recv[1]),
      .dat_ready(rdy[1]), .dat_o(dat1), .parity_err(pe[1]),
      .frame_err(fe[1]), .break_det(bk[1]));

   uart_rx_cfg #(.G_STOP_BITS(2)) u_8n2 (
      .clk(clk), .rst(rst), .uart_rx(line[2]), .receiving(recv[2]),
      .dat_ready(rdy[2]), .dat_o(dat2), .parity_err(pe[2]),
      .frame_err(fe[2]), .break_det(bk[2]));

   uart_rx_cfg #(.G_DATA_BITS(7)) u_7n1 (
      .clk(clk), .rst(rst), .uart_rx(line[3]), .receiving(recv[3]),
      .dat_ready(rdy[3]), .dat_o(dat3), .parity_err(pe[3]),
      .frame_err(fe[3]), .break_det(bk[3]));

   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (rdy[i] === 1'b1) begin
            rdy_cnt[i] = rdy_cnt[i] + 1;
            rdy_cyc[i] = cyc;
            cap_dat[i] = datv[i];
            cap_pe[i]  = pe[i];
            cap_fe[i]  = fe[i];
            cap_bk[i]  = bk[i];
         end
         if (recv[i] === 1'b1 && recv_prev[i] !== 1'b1) rise_cyc[i] = cyc;
         if (recv[i] === 1'b0 && recv_prev[i] === 1'b1) fall_cyc[i] = cyc;
         recv_prev[i] = recv[i];
      end
   end

   function automatic exp_t model(input logic [8:0] data, input int nbits,
                                  input int par, input logic pbit,
                                  input logic s1, input logic s2,
                                  input int nstop);
      exp_t e;
      int ones;
      int mask;
      mask  = (1 << nbits) - 1;
      e.dat = 9'(int'(data) & mask);
      ones  = $countones(e.dat) + ((par != 0) ? int'(pbit) : 0);
      e.pe  = (par == 1) ? (ones % 2 == 0) :
              (par == 2) ? (ones % 2 == 1) : 1'b0;
      e.fe  = !s1 || (nstop == 2 && !s2);
      e.bk  = e.fe && (e.dat == 9'd0);
      return e;
   endfunction

   task automatic drive(input int idx, input logic v, input int n);
      line[idx] = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input int idx, input logic [8:0] data,
                             input int nbits, input int par,
                             input logic pbit, input logic s1,
                             input logic s2, input int nstop,
                             output int c0);
      @(posedge clk);
      #1;
      c0 = cyc;
      drive(idx, 1'b0, DIV);
      for (int i = 0; i < nbits; i++) drive(idx, data[i], DIV);
      if (par != 0) drive(idx, pbit, DIV);
      drive(idx, s1, DIV);
      if (nstop == 2) drive(idx, s2, DIV);
      line[idx] = 1'b1;
      repeat (30) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) line[i] = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         n_chk++;
         if ({recv[i], rdy[i], datv[i], pe[i], fe[i], bk[i]} !== 14'd0)
            $display("FAIL reset[%0d]: got %h required 0", i,
                     {recv[i], rdy[i], datv[i], pe[i], fe[i], bk[i]});
         else n_pass++;
      end
      rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
   endtask

   task automatic test_8n1_timing();
      int c0, n0;
      n0 = rdy_cnt[0];
      send_frame(0, 9'h0A5, 8, 0, 1'b0, 1'b1, 1'b1, 1, c0);
      n_chk++;
      if (rdy_cnt[0] - n0 != 1 || cap_dat[0] !== 9'h0A5 ||
          {cap_pe[0], cap_fe[0], cap_bk[0]} !== 3'b000)
         $display("FAIL a5_frame: got n=%0d dat=%h flags=%b%b%b required n=1 dat=a5 flags=000",
                  rdy_cnt[0] - n0, cap_dat[0], cap_pe[0], cap_fe[0], cap_bk[0]);
      else n_pass++;
      n_chk++;
      if (rdy_cyc[0] != c0 + 2 + HALF + 9 * DIV + 1)
         $display("FAIL a5_ready_cycle: got %0d required %0d",
                  rdy_cyc[0] - c0, 2 + HALF + 9 * DIV + 1);
      else n_pass++;
      n_chk++;
      if (rise_cyc[0] != c0 + 3)
         $display("FAIL a5_recv_rise: got %0d required 3", rise_cyc[0] - c0);
      else n_pass++;
      n_chk++;
      if (fall_cyc[0] != c0 + 2 + HALF + 9 * DIV + 1)
         $display("FAIL a5_recv_fall: got %0d required %0d",
                  fall_cyc[0] - c0, 2 + HALF + 9 * DIV + 1);
      else n_pass++;
   endtask

   task automatic test_random_frames(input int idx, input int nbits,
                                     input int par, input int nstop,
                                     input int count);
      int c0, n0;
      logic [8:0] data;
      logic pbit, s1, s2;
      exp_t e;
      for (int k = 0; k < count; k++) begin
         data = 9'($urandom_range(0, (1 << nbits) - 1));
         if (k == 0) data = 9'd0;
         pbit = 1'($urandom_range(0, 1));
         s1   = ($urandom_range(0, 3) != 0);
         s2   = ($urandom_range(0, 3) != 0);
         n0   = rdy_cnt[idx];
         send_frame(idx, data, nbits, par, pbit, s1, s2, nstop, c0);
         e = model(data, nbits, par, pbit, s1, s2, nstop);
         n_chk++;
         if (rdy_cnt[idx] - n0 != 1 ||
             {cap_dat[idx], cap_pe[idx], cap_fe[idx], cap_bk[idx]} !== e)
            $display("FAIL rand[%0d].%0d: got n=%0d dat=%h pe=%b fe=%b bk=%b required n=1 dat=%h pe=%b fe=%b bk=%b",
                     idx, k, rdy_cnt[idx] - n0, cap_dat[idx], cap_pe[idx],
                     cap_fe[idx], cap_bk[idx], e.dat, e.pe, e.fe, e.bk);
         else n_pass++;
      end
   endtask

   task automatic test_parity();
      int c0, n0;
      logic pb;
      for (int k = 0; k < 2; k++) begin
         pb = (k == 1);
         n0 = rdy_cnt[1];
         send_frame(1, 9'h003, 8, 2, pb, 1'b1, 1'b1, 1, c0);
         n_chk++;
         if (rdy_cnt[1] - n0 != 1 || cap_dat[1] !== 9'h003 ||
             cap_pe[1] !== pb || cap_fe[1] !== 1'b0)
            $display("FAIL parity_03_p%0d: got n=%0d dat=%h pe=%b fe=%b required n=1 dat=03 pe=%b fe=0",
                     k, rdy_cnt[1] - n0, cap_dat[1], cap_pe[1], cap_fe[1], pb);
         else n_pass++;
      end
   endtask

   task automatic test_glitch();
      int c0, n0;
      logic [11:0] snap;
      n0   = rdy_cnt[0];
      snap = {datv[0], pe[0], fe[0], bk[0]};
      @(posedge clk);
      #1;
      c0 = cyc;
      drive(0, 1'b0, 20);
      line[0] = 1'b1;
      repeat (100) @(posedge clk);
      #1;
      n_chk++;
      if (rdy_cnt[0] != n0 || {datv[0], pe[0], fe[0], bk[0]} !== snap)
         $display("FAIL glitch_hold: got n=%0d out=%h required n=0 out=%h",
                  rdy_cnt[0] - n0, {datv[0], pe[0], fe[0], bk[0]}, snap);
      else n_pass++;
      n_chk++;
      if (rise_cyc[0] != c0 + 3 || fall_cyc[0] != c0 + 3 + HALF)
         $display("FAIL glitch_recv: got rise=%0d fall=%0d required rise=3 fall=%0d",
                  rise_cyc[0] - c0, fall_cyc[0] - c0, 3 + HALF);
      else n_pass++;
   endtask

   task automatic test_stop2();
      int c0, n0;
      n0 = rdy_cnt[2];
      send_frame(2, 9'h05A, 8, 0, 1'b0, 1'b1, 1'b0, 2, c0);
      n_chk++;
      if (rdy_cnt[2] - n0 != 1 || cap_dat[2] !== 9'h05A ||
          {cap_pe[2], cap_fe[2], cap_bk[2]} !== 3'b010)
         $display("FAIL stop2_low: got n=%0d dat=%h flags=%b%b%b required n=1 dat=5a flags=010",
                  rdy_cnt[2] - n0, cap_dat[2], cap_pe[2], cap_fe[2], cap_bk[2]);
      else n_pass++;
   endtask

   task automatic test_break();
      int c0, n0;
      n0 = rdy_cnt[0];
      @(posedge clk);
      #1;
      drive(0, 1'b0, 3 * 10 * DIV);
      n_chk++;
      if (rdy_cnt[0] - n0 != 1 || cap_dat[0] !== 9'h000 ||
          {cap_pe[0], cap_fe[0], cap_bk[0]} !== 3'b011 || recv[0] !== 1'b0)
         $display("FAIL break: got n=%0d dat=%h flags=%b%b%b recv=%b required n=1 dat=00 flags=011 recv=0",
                  rdy_cnt[0] - n0, cap_dat[0], cap_pe[0], cap_fe[0],
                  cap_bk[0], recv[0]);
      else n_pass++;
      line[0] = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      n0 = rdy_cnt[0];
      send_frame(0, 9'h041, 8, 0, 1'b0, 1'b1, 1'b1, 1, c0);
      n_chk++;
      if (rdy_cnt[0] - n0 != 1 || cap_dat[0] !== 9'h041 ||
          {cap_pe[0], cap_fe[0], cap_bk[0]} !== 3'b000)
         $display("FAIL after_break_41: got n=%0d dat=%h flags=%b%b%b required n=1 dat=41 flags=000",
                  rdy_cnt[0] - n0, cap_dat[0], cap_pe[0], cap_fe[0], cap_bk[0]);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int c0, n0;
      logic [8:0] d;
      d  = 9'h07E;
      n0 = rdy_cnt[0];
      @(posedge clk);
      #1;
      drive(0, 1'b0, DIV);
      for (int i = 0; i < 4; i++) drive(0, d[i], DIV);
      drive(0, d[4], 50);
      rst = 1'b1;
      @(posedge clk);
      #1;
      n_chk++;
      if ({recv[0], rdy[0], datv[0], pe[0], fe[0], bk[0]} !== 14'd0)
         $display("FAIL mid_reset: got %h required 0",
                  {recv[0], rdy[0], datv[0], pe[0], fe[0], bk[0]});
      else n_pass++;
      rst = 1'b0;
      line[0] = 1'b1;
      repeat (1200) @(posedge clk);
      #1;
      n_chk++;
      if (rdy_cnt[0] != n0)
         $display("FAIL mid_reset_no_ready: got %0d pulses required 0",
                  rdy_cnt[0] - n0);
      else n_pass++;
      send_frame(0, d, 8, 0, 1'b0, 1'b1, 1'b1, 1, c0);
      n_chk++;
      if (rdy_cnt[0] - n0 != 1 || cap_dat[0] !== 9'h07E ||
          {cap_pe[0], cap_fe[0], cap_bk[0]} !== 3'b000)
         $display("FAIL post_reset_7e: got n=%0d dat=%h flags=%b%b%b required n=1 dat=7e flags=000",
                  rdy_cnt[0] - n0, cap_dat[0], cap_pe[0], cap_fe[0], cap_bk[0]);
      else n_pass++;
   endtask

   task automatic test_7bit();
      int c0, n0;
      n0 = rdy_cnt[3];
      send_frame(3, 9'h07E, 7, 0, 1'b0, 1'b1, 1'b1, 1, c0);
      n_chk++;
      if (rdy_cnt[3] - n0 != 1 || cap_dat[3] !== 9'h07E ||
          {cap_pe[3], cap_fe[3], cap_bk[3]} !== 3'b000)
         $display("FAIL 7bit_7e: got n=%0d dat=%h flags=%b%b%b required n=1 dat=7e flags=000",
                  rdy_cnt[3] - n0, cap_dat[3], cap_pe[3], cap_fe[3], cap_bk[3]);
      else n_pass++;
   endtask

   initial begin
      for (int i = 0; i < 4; i++) begin
         recv_prev[i] = 1'b0;
         rdy_cnt[i]   = 0;
         line[i]      = 1'b1;
      end
      test_reset();
      test_8n1_timing();
      test_random_frames(0, 8, 0, 1, 5);
      test_parity();
      test_random_frames(1, 8, 2, 1, 5);
      test_glitch();
      test_stop2();
      test_random_frames(2, 8, 0, 2, 4);
      test_break();
      test_reset_mid();
      test_7bit();
      test_random_frames(3, 7, 0, 1, 4);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
